lfsr_rr_sched: RTL

- Round-robin scheduler that shares one external 16-bit-output LFSR noise source among NREQ requesters.
- Drives the LFSR's enable and synchronous reset, and advances it STEPS clocks per granted request so that each delivered word is decorrelated from the previous one.
- Samples the LFSR's out16 and returns the word to the granted requester with a one-cycle valid strobe.
- Sits between the LFSR instance and the noise consumers (voices/modulators).

---
 rtl/lfsr_rr_sched.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/lfsr_rr_sched.sv
// Round-robin scheduler sharing one external 16-bit LFSR among NREQ requesters.
// Define LFSR_RR_SCHED_FIXED_PRIO_EN for fixed (lowest-index-wins) priority instead of round-robin.
module lfsr_rr_sched #(
    parameter int NREQ  = 4,
    parameter int STEPS = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            reseed,
    input  logic [15:0]     lfsr_out16,
    output logic            lfsr_enable,
    output logic            lfsr_reset,
    output logic [NREQ-1:0] gnt,
    output logic [15:0]     rnd_data,
    output logic            rnd_valid,
    output logic            busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // state     | meaning
    // S_INIT    | one-cycle lfsr_reset pulse, clears pending reseed
    // S_IDLE    | honour pending reseed, else arbitrate requests
    // S_STEP    | lfsr_enable high for STEPS cycles
    // S_CAPTURE | sample lfsr_out16 into rnd_data
    // S_DELIVER | rnd_valid high, grant released on exit
    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_STEP,
        S_CAPTURE,
        S_DELIVER
    } state_t;

    state_t          state;
    logic            reseed_pend;
    logic [7:0]      step_cnt;
    logic [PW-1:0]   win_idx;
    logic            win_found;

`ifdef LFSR_RR_SCHED_FIXED_PRIO_EN
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_idx   = PW'(i);
                win_found = 1'b1;
            end
        end
    end
`else
    logic [PW-1:0] ptr;

    // Second pass overrides the first: lowest index above ptr wins, else wrap to lowest overall.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i] && (PW'(i) <= ptr)) begin
                win_idx   = PW'(i);
                win_found = 1'b1;
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i] && (PW'(i) > ptr)) begin
                win_idx   = PW'(i);
                win_found = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_INIT;
            gnt         <= '0;
            rnd_data    <= 16'h0000;
            rnd_valid   <= 1'b0;
            lfsr_enable <= 1'b0;
            lfsr_reset  <= 1'b0;
            busy        <= 1'b1;
            reseed_pend <= 1'b0;
            step_cnt    <= '0;
`ifndef LFSR_RR_SCHED_FIXED_PRIO_EN
            ptr         <= PW'(NREQ - 1);
`endif
        end else begin
            if (reseed) begin
                reseed_pend <= 1'b1;
            end
            case (state)
                // Out of async reset lfsr_reset is still low, so INIT spends one extra
                // cycle raising it; entered from IDLE it is already high and exits at once.
                S_INIT: begin
                    if (!lfsr_reset) begin
                        lfsr_reset <= 1'b1;
                    end else begin
                        lfsr_reset  <= 1'b0;
                        reseed_pend <= reseed;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (reseed_pend || reseed) begin
                        lfsr_reset <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_INIT;
                    end else if (win_found) begin
                        gnt         <= NREQ'(1) << win_idx;
`ifndef LFSR_RR_SCHED_FIXED_PRIO_EN
                        ptr         <= win_idx;
`endif
                        step_cnt    <= 8'(STEPS - 1);
                        lfsr_enable <= 1'b1;
                        busy        <= 1'b1;
                        state       <= S_STEP;
                    end
                end
                S_STEP: begin
                    if (step_cnt == 8'd0) begin
                        lfsr_enable <= 1'b0;
                        state       <= S_CAPTURE;
                    end else begin
                        step_cnt <= step_cnt - 8'd1;
                    end
                end
                S_CAPTURE: begin
                    rnd_data  <= lfsr_out16;
                    rnd_valid <= 1'b1;
                    state     <= S_DELIVER;
                end
                S_DELIVER: begin
                    rnd_valid <= 1'b0;
                    gnt       <= '0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

endmodule
